// File: rtl/dds_chirp_burst_generator.sv
// dds_chirp_burst_generator: quadrature chirp NCO with burst start/stop control.
// Each sample passes through a six-stage pipeline: phase add, round/address/sign,
// ROM read, two's complement, multiply, output register.
// Optional build macro DDS_PHASE_DITHER_EN adds LFSR phase dither ahead of rounding.
module dds_chirp_burst_generator #(
   parameter int WIDTH_NCO      = 16,
   parameter int WIDTH_PHASE    = 32,
   parameter int WIDTH_ADDR_ROM = 10,
   parameter int WIDTH_LEN      = 16,
   parameter     INIT_ROM_FILE  = "sin_nco.dat"
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stop,
   input  logic [WIDTH_PHASE-1:0] freq_start,
   input  logic [WIDTH_PHASE-1:0] freq_step,
   input  logic [WIDTH_PHASE-1:0] phase,
   input  logic [WIDTH_NCO-1:0]   amplitude,
   input  logic [WIDTH_LEN-1:0]   burst_len,
   output logic [WIDTH_NCO-1:0]   real_sig,
   output logic [WIDTH_NCO-1:0]   imag_sig,
   output logic [WIDTH_PHASE-1:0] phase_out,
   output logic                   valid,
   output logic                   last,
   output logic                   busy
);

   localparam int ROM_DEPTH = 2**WIDTH_ADDR_ROM;
   localparam int MAG_MAX   = 2**(WIDTH_NCO-1) - 1;
   localparam int TOP_W     = WIDTH_ADDR_ROM + 3;
   localparam logic [WIDTH_PHASE-1:0] QUARTER = WIDTH_PHASE'(1) << (WIDTH_PHASE-2);

   // The quarter-wave table is generated at elaboration from the same formula that
   // produces the init file, so the build needs no data file; the name is kept for
   // flows that substitute a file-loaded ROM.
   localparam logic [$bits(INIT_ROM_FILE)-1:0] rom_file_unused = INIT_ROM_FILE;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t state_q, state_d;
   logic                          start_q, start_rise, issue, last_issue;
   logic [WIDTH_PHASE-1:0]        freq_r, step_r, phase_r, acc;
   logic signed [WIDTH_NCO-1:0]   amp_r;
   logic [WIDTH_LEN-1:0]          len_r, k;
   logic [WIDTH_PHASE-1:0]        dither;
   logic [TOP_W-1:0]              sin_top, cos_top;
   logic [4:0]                    vpipe, lpipe;
   logic [WIDTH_PHASE-1:0]        s1_ph, s2_ph, s3_ph, s4_ph, s5_ph;
   logic [WIDTH_ADDR_ROM:0]       s2_sin, s2_cos;
   logic [WIDTH_NCO-2:0]          s3_sin_mag, s3_cos_mag;
   logic                          s3_sin_neg, s3_cos_neg;
   logic signed [WIDTH_NCO-1:0]   s4_sin, s4_cos;
   logic signed [2*WIDTH_NCO-1:0] s5_sin, s5_cos;
   logic [WIDTH_NCO-2:0]          sine_rom [ROM_DEPTH];

   function automatic logic [WIDTH_NCO-2:0] rom_entry(input int idx);
      real angle;
      int  mag;
      angle = 1.5707963267948966 * real'(idx) / real'(ROM_DEPTH);
      mag = $rtoi(real'(MAG_MAX) * $sin(angle) + 0.5);
      rom_entry = (WIDTH_NCO-1)'(mag);
   endfunction

   // Rounds the top phase bits half-up, then folds into {negative, quarter-wave address}.
   function automatic logic [WIDTH_ADDR_ROM:0] map_phase(input logic [TOP_W-1:0] top);
      logic [WIDTH_ADDR_ROM+1:0] r;
      r = top[TOP_W-1:1] + (WIDTH_ADDR_ROM+2)'(top[0]);
      map_phase = {r[WIDTH_ADDR_ROM+1],
                   r[WIDTH_ADDR_ROM] ? ~r[WIDTH_ADDR_ROM-1:0] : r[WIDTH_ADDR_ROM-1:0]};
   endfunction

   for (genvar i = 0; i < ROM_DEPTH; i++) begin : g_rom
      assign sine_rom[i] = rom_entry(i);
   end

   assign start_rise = start & ~start_q;
   assign busy       = (state_q != IDLE);

`ifdef DDS_PHASE_DITHER_EN
   localparam int DITHER_SHIFT = WIDTH_ADDR_ROM + 19;
   logic [15:0] lfsr;

   // Galois LFSR (x^16+x^14+x^13+x^11+1) steps every clock, reseeded per burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lfsr <= 16'hACE1;
      else if (state_q == IDLE && start_rise)
         lfsr <= 16'hACE1;
      else
         lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   end

   assign dither = WIDTH_PHASE'({lfsr, {WIDTH_PHASE{1'b0}}} >> DITHER_SHIFT);
`else
   assign dither = '0;
`endif

   assign sin_top = TOP_W'((s1_ph + dither) >> (WIDTH_PHASE - TOP_W));
   assign cos_top = TOP_W'((s1_ph + QUARTER + dither) >> (WIDTH_PHASE - TOP_W));

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Next state plus sample-issue decisions; stop is only honoured while running.
   always_comb begin
      state_d    = state_q;
      issue      = 1'b0;
      last_issue = 1'b0;
      unique case (state_q)
         IDLE:  if (start_rise) state_d = RUN;
         RUN: begin
            issue      = 1'b1;
            last_issue = stop || (len_r != '0 && k == len_r - WIDTH_LEN'(1));
            if (last_issue) state_d = DRAIN;
         end
         DRAIN: if (last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Burst parameters latch on the start edge; frequency and accumulator advance per sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         start_q <= 1'b0;
         freq_r  <= '0;
         step_r  <= '0;
         phase_r <= '0;
         amp_r   <= '0;
         len_r   <= '0;
         acc     <= '0;
         k       <= '0;
      end else begin
         start_q <= start;
         if (state_q == IDLE && start_rise) begin
            freq_r  <= freq_start;
            step_r  <= freq_step;
            phase_r <= phase;
            amp_r   <= amplitude;
            len_r   <= burst_len;
            acc     <= '0;
            k       <= '0;
         end else if (issue) begin
            acc    <= acc + freq_r;
            freq_r <= freq_r + step_r;
            k      <= k + WIDTH_LEN'(1);
         end
      end
   end

   // Five internal pipeline stages; valid/last/phase ride alongside each sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vpipe      <= '0;
         lpipe      <= '0;
         s1_ph      <= '0;
         s2_ph      <= '0;
         s3_ph      <= '0;
         s4_ph      <= '0;
         s5_ph      <= '0;
         s2_sin     <= '0;
         s2_cos     <= '0;
         s3_sin_mag <= '0;
         s3_cos_mag <= '0;
         s3_sin_neg <= 1'b0;
         s3_cos_neg <= 1'b0;
         s4_sin     <= '0;
         s4_cos     <= '0;
         s5_sin     <= '0;
         s5_cos     <= '0;
      end else begin
         vpipe      <= {vpipe[3:0], issue};
         lpipe      <= {lpipe[3:0], last_issue};
         s1_ph      <= phase_r + acc;
         s2_ph      <= s1_ph;
         s2_sin     <= map_phase(sin_top);
         s2_cos     <= map_phase(cos_top);
         s3_ph      <= s2_ph;
         s3_sin_mag <= sine_rom[s2_sin[WIDTH_ADDR_ROM-1:0]];
         s3_cos_mag <= sine_rom[s2_cos[WIDTH_ADDR_ROM-1:0]];
         s3_sin_neg <= s2_sin[WIDTH_ADDR_ROM];
         s3_cos_neg <= s2_cos[WIDTH_ADDR_ROM];
         s4_ph      <= s3_ph;
         s4_sin     <= s3_sin_neg ? -$signed({1'b0, s3_sin_mag}) : $signed({1'b0, s3_sin_mag});
         s4_cos     <= s3_cos_neg ? -$signed({1'b0, s3_cos_mag}) : $signed({1'b0, s3_cos_mag});
         s5_ph      <= s4_ph;
         s5_sin     <= (2*WIDTH_NCO)'(s4_sin) * (2*WIDTH_NCO)'(amp_r);
         s5_cos     <= (2*WIDTH_NCO)'(s4_cos) * (2*WIDTH_NCO)'(amp_r);
      end
   end

   // Output register: data updates only with a valid sample, otherwise holds.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         real_sig  <= '0;
         imag_sig  <= '0;
         phase_out <= '0;
         valid     <= 1'b0;
         last      <= 1'b0;
      end else begin
         valid <= vpipe[4];
         last  <= vpipe[4] & lpipe[4];
         if (vpipe[4]) begin
            real_sig  <= WIDTH_NCO'(s5_cos >>> (WIDTH_NCO-1));
            imag_sig  <= WIDTH_NCO'(s5_sin >>> (WIDTH_NCO-1));
            phase_out <= s5_ph;
         end
      end
   end

endmodule

// File: tb/tb_dds_chirp_burst_generator.sv
// tb_dds_chirp_burst_generator: directed and randomised bursts compared against a
// closed-form chirp/sine reference model.
`timescale 1ns/1ps
module tb_dds_chirp_burst_generator;

   logic        clk = 1'b0;
   logic        reset, start, stop;
   logic [31:0] freq_start, freq_step, phase;
   logic [15:0] amplitude, burst_len;
   logic [15:0] real_sig, imag_sig;
   logic [31:0] phase_out;
   logic        valid, last, busy;
   int          testCount = 0;
   int          failCount = 0;

   always #5 clk = ~clk;

   dds_chirp_burst_generator dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .freq_start(freq_start), .freq_step(freq_step), .phase(phase),
      .amplitude(amplitude), .burst_len(burst_len),
      .real_sig(real_sig), .imag_sig(imag_sig), .phase_out(phase_out),
      .valid(valid), .last(last), .busy(busy)
   );

   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Phase of sample k: phase + k*f0 + k(k-1)/2*step, modulo 2^32.
   function automatic logic [31:0] modelPhase(input logic [31:0] ph0, input logic [31:0] fs,
                                              input logic [31:0] st, input int k);
      logic [63:0] kk, triN, sum;
      kk   = 64'(k);
      triN = (kk * (kk - 64'd1)) / 64'd2;
      sum  = {32'b0, ph0} + kk * {32'b0, fs} + triN * {{32{st[31]}}, st};
      return sum[31:0];
   endfunction

   function automatic int romValue(input int idx);
      real angle;
      angle = 1.5707963267948966 * real'(idx) / 1024.0;
      return $rtoi(32767.0 * $sin(angle) + 0.5);
   endfunction

   // Full-wave sine from a 32-bit phase: round to 4096 steps per turn, fold by quadrant.
   function automatic int sineOf(input logic [31:0] ph);
      longint q;
      int     quad, a, mag;
      q    = ((longint'({32'b0, ph}) + 64'sd524288) / 64'sd1048576) % 64'sd4096;
      quad = int'(q / 64'sd1024);
      a    = int'(q % 64'sd1024);
      if (quad % 2 == 1) a = 1023 - a;
      mag = romValue(a);
      return (quad >= 2) ? -mag : mag;
   endfunction

   function automatic int scaled(input int s, input logic [15:0] amp);
      longint p;
      logic [63:0] pv;
      p  = longint'(s) * longint'($signed(amp));
      p  = p >>> 15;
      pv = p;
      return int'($signed(pv[15:0]));
   endfunction

   // Runs one burst: drives start (optionally with stop), an optional stop at sample
   // stopAt, an optional start pulse while draining, and checks every emitted sample.
   task automatic applyStimulus(input logic [31:0] fs, input logic [31:0] st,
                                input logic [31:0] ph, input logic [15:0] amp,
                                input logic [15:0] len, input int stopAt,
                                input bit stopWithStart, input bit startInDrain);
      int n, cyc, seen, firstLat, idleValids, expRe, expIm, expReLast;
      logic [31:0] expPh;
      bit done;
      n = (len != 0 && (stopAt < 0 || stopAt >= int'(len))) ? int'(len) : stopAt + 1;
      freq_start = fs; freq_step = st; phase = ph; amplitude = amp; burst_len = len;
      start = 1'b1;
      stop  = stopWithStart;
      @(posedge clk); #1;
      start = 1'b0;
      freq_start = $urandom(); freq_step = $urandom(); phase = $urandom();
      amplitude = 16'($urandom()); burst_len = 16'($urandom());
      cyc = 0; seen = 0; firstLat = -1; done = 1'b0; expReLast = 0;
      while (!done && cyc < n + 40) begin
         stop  = (cyc == stopAt);
         start = startInDrain && (cyc >= n + 1);
         @(posedge clk); #1;
         cyc++;
         if (valid) begin
            if (firstLat < 0) firstLat = cyc;
            if (seen < n) begin
               expPh = modelPhase(ph, fs, st, seen);
               expIm = scaled(sineOf(expPh), amp);
               expRe = scaled(sineOf(expPh + 32'h4000_0000), amp);
               expReLast = expRe;
               checkOutput("phase_out", phase_out, expPh);
               checkOutput("imag_sig", $signed(imag_sig), expIm);
               checkOutput("real_sig", $signed(real_sig), expRe);
               checkOutput("last", last, seen == n - 1);
            end
            seen++;
         end
         if (!busy) done = 1'b1;
      end
      stop = 1'b0;
      checkOutput("sample_count", seen, n);
      checkOutput("first_valid_latency", firstLat, 6);
      checkOutput("busy_drop_cycle", cyc, n + 6);
      idleValids = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (valid || busy) idleValids++;
      end
      start = 1'b0;
      checkOutput("idle_after_burst", idleValids, 0);
      checkOutput("hold_real_sig", $signed(real_sig), expReLast);
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      int lenR, stopR, midValids;
      logic [31:0] fsR, stR, phR;
      logic [15:0] ampR;
      reset = 1'b1; start = 1'b0; stop = 1'b0;
      freq_start = '0; freq_step = '0; phase = '0; amplitude = '0; burst_len = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_last", last, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_real", real_sig, 0);
      checkOutput("reset_imag", imag_sig, 0);
      checkOutput("reset_phase_out", phase_out, 0);
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] tone at Fs/4");
      applyStimulus(32'h4000_0000, 32'h0, 32'h0, 16'h7FFF, 16'd8, -1, 1'b0, 1'b0);
      $display("[TB] chirp");
      applyStimulus(32'h0, 32'h0010_0000, 32'h8000_0000, 16'h7FFF, 16'd16, -1, 1'b0, 1'b0);
      $display("[TB] early stop with start during drain");
      applyStimulus(32'h0123_4567, 32'h0000_1000, 32'h1000_0000, 16'h6000, 16'd0, 20, 1'b0, 1'b1);
      $display("[TB] simultaneous events");
      applyStimulus(32'h0800_0000, 32'h0, 32'h0, 16'h7FFF, 16'd8, -1, 1'b1, 1'b0);
      applyStimulus(32'h0200_0000, 32'hFFF0_0000, 32'h2000_0000, 16'h7FFF, 16'd5, 4, 1'b0, 1'b0);

      $display("[TB] reset mid-burst");
      freq_start = 32'h0300_0000; freq_step = 32'h100; phase = 32'h1234_5678;
      amplitude = 16'h7FFF; burst_len = 16'd100; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkOutput("midreset_valid", valid, 0);
      checkOutput("midreset_busy", busy, 0);
      checkOutput("midreset_real", real_sig, 0);
      checkOutput("midreset_imag", imag_sig, 0);
      checkOutput("midreset_phase_out", phase_out, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      midValids = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (valid || last || busy) midValids++;
      end
      checkOutput("after_reset_quiet", midValids, 0);
      applyStimulus(32'h0300_0000, 32'h100, 32'h1234_5678, 16'h7FFF, 16'd6, -1, 1'b0, 1'b0);

      $display("[TB] amplitude and wrap");
      applyStimulus(32'hFFFF_FFFF, 32'h1, 32'h0, 16'h4000, 16'd4, -1, 1'b0, 1'b0);

      $display("[TB] randomised bursts");
      for (int i = 0; i < 10; i++) begin
         fsR  = $urandom();
         stR  = $urandom();
         phR  = $urandom();
         ampR = 16'($urandom());
         lenR = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 24));
         stopR = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 30));
         if (lenR == 0 && stopR < 0) stopR = int'($urandom_range(0, 30));
         applyStimulus(fsR, stR, phR, ampR, 16'(lenR), stopR, 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
